// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package spram_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int PTR_W   = $clog2(MAX_REQ);

  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Index of the set bit of a one-hot vector (zero when no bit is set).
  function automatic ptr_t oh_to_idx(input logic [MAX_REQ-1:0] oh);
    ptr_t idx;
    idx = ptr_t'(0);
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = idx | ({PTR_W{oh[i]}} & ptr_t'(i));
    end
    return idx;
  endfunction

  // Round-robin start position after granting the one-hot winner oh among n requesters.
  function automatic ptr_t rr_next(input logic [MAX_REQ-1:0] oh, input int n);
    ptr_t idx;
    idx = oh_to_idx(oh);
    return (idx == ptr_t'(n - 1)) ? ptr_t'(0) : idx + ptr_t'(1);
  endfunction

endpackage

// File: rtl/spram_arb_if.sv
// Requester-side command and response channels of the RAM arbiter.
interface spram_arb_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM: write when cs&we, registered read when cs&oe&!we.
module single_port_sync_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (cs && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read data register, valid the cycle after a read command.
  always_ff @(posedge clk) begin
    if (cs && oe && !we) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/spram_arb_pick.sv
// Combinational winner select: first valid requester at or after ptr, one-hot grant.
module spram_arb_pick
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  ptr_t               ptr,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int IW = PTR_W + 1;

  logic          found_s;
  logic [IW-1:0] idx_s;

  // Scan requesters in priority order starting at ptr, wrapping at NUM_REQ.
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = {1'b0, ptr} + IW'(k);
      if (idx_s >= IW'(NUM_REQ)) begin
        idx_s = idx_s - IW'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_s && (idx_s == IW'(i)) && req_valid[i]) begin
          gnt[i]  = 1'b1;
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single_port_sync_ram between NUM_REQ requesters (IDLE/CMD/CAPT/RESP sequencer).
// Build option SPRAM_ARB_RR_EN selects round-robin arbitration; default is fixed priority.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int NUM_REQ    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spram_arb_if.slave            bus,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("spram_arbiter: DEPTH must equal 2**ADDR_WIDTH");
  end
  if ((NUM_REQ < 2) || (NUM_REQ > MAX_REQ)) begin : g_num_req_check
    $error("spram_arbiter: NUM_REQ out of range 2..8");
  end

  state_t                  state_r;
  state_t                  state_nxt_s;
  ptr_t                    ptr_s;
  logic [NUM_REQ-1:0]      gnt_s;
  logic [NUM_REQ-1:0]      req_ready_s;
  logic                    accept_s;
  logic [NUM_REQ-1:0]      own_r;
  logic [NUM_REQ-1:0]      own_nxt_s;
  logic                    we_r;
  logic                    we_nxt_s;
  logic                    sel_we_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic                    ram_cs_r;
  logic                    ram_we_r;
  logic                    ram_oe_r;
  logic [ADDR_WIDTH-1:0]   ram_addr_r;
  logic [DATA_WIDTH-1:0]   ram_wdata_r;
  logic [NUM_REQ-1:0]      rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_data_r;

  spram_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr_s),
    .gnt       (gnt_s)
  );

  // AND-OR mux of the winning requester's command fields.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_we_s    = sel_we_s | (gnt_s[i] & bus.req_we[i]);
      sel_addr_s  = sel_addr_s | ({ADDR_WIDTH{gnt_s[i]}} & bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      sel_wdata_s = sel_wdata_s | ({DATA_WIDTH{gnt_s[i]}} & bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Next-state and handshake decode; req_ready is forced low while rst_n is asserted.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    req_ready_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (rst_n && (|gnt_s)) begin
          req_ready_s = gnt_s;
          accept_s    = 1'b1;
          state_nxt_s = ST_CMD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (we_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CAPT;
        end
      end
      ST_CAPT: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        if (|(bus.rsp_ready & own_r)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign own_nxt_s = accept_s ? gnt_s : own_r;
  assign we_nxt_s  = accept_s ? sel_we_s : we_r;

  // FSM state and latched owner/direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      own_r   <= '0;
      we_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      own_r   <= own_nxt_s;
      we_r    <= we_nxt_s;
    end
  end

  // RAM controls are registered from the next state so they line up with CMD/CAPT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_oe_r    <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
    end else begin
      ram_cs_r <= (state_nxt_s == ST_CMD) || (state_nxt_s == ST_CAPT);
      ram_we_r <= (state_nxt_s == ST_CMD) && we_nxt_s;
      ram_oe_r <= ((state_nxt_s == ST_CMD) && !we_nxt_s) || (state_nxt_s == ST_CAPT);
      if (accept_s) begin
        ram_addr_r  <= sel_addr_s;
        ram_wdata_r <= sel_wdata_s;
      end
    end
  end

  // Response channel: data captured in CAPT, valid to the owner throughout RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
    end else begin
      rsp_valid_r <= (state_nxt_s == ST_RESP) ? own_nxt_s : '0;
      if (state_r == ST_CAPT) begin
        rsp_data_r <= ram_rdata;
      end
    end
  end

`ifdef SPRAM_ARB_RR_EN
  ptr_t ptr_r;

  // Round-robin start pointer, advanced only on an accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= ptr_t'(0);
    end else if (accept_s) begin
      ptr_r <= rr_next(MAX_REQ'(gnt_s), NUM_REQ);
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = ptr_t'(0);
`endif

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign ram_cs        = ram_cs_r;
  assign ram_we        = ram_we_r;
  assign ram_oe        = ram_oe_r;
  assign ram_addr      = ram_addr_r;
  assign ram_wdata     = ram_wdata_r;

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter with a behavioural memory/arbitration model.
module tb_spram_arbiter;

  localparam int AW      = 4;
  localparam int DW      = 32;
  localparam int DEPTH   = 16;
  localparam int NUM_REQ = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  spram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NUM_REQ)) bus ();

  spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  single_port_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .cs    (ram_cs),
    .we    (ram_we),
    .oe    (ram_oe),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            mptr     = 0;
  logic [DW-1:0] mem [DEPTH];
  logic          cmd_we   [NUM_REQ];
  logic [AW-1:0] cmd_addr [NUM_REQ];
  logic [DW-1:0] cmd_data [NUM_REQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  // Expected winner: lowest index (fixed) or first valid from the model pointer (round-robin).
  function automatic logic [NUM_REQ-1:0] model_pick(input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SPRAM_ARB_RR_EN
      int i = (mptr + k) % NUM_REQ;
`else
      int i = k;
`endif
      if (v[i]) return oh(i);
    end
    return '0;
  endfunction

  task automatic set_cmd(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_we[r]   = we;
    cmd_addr[r] = a;
    cmd_data[r] = d;
  endtask

  task automatic drive(input logic [NUM_REQ-1:0] vmask);
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.req_we[r]               = cmd_we[r];
      bus.req_addr[r*AW +: AW]    = cmd_addr[r];
      bus.req_wdata[r*DW +: DW]   = cmd_data[r];
    end
    bus.req_valid = vmask;
  endtask

  // One full transaction from IDLE: grant, RAM command, and (for reads) response with hold cycles.
  task automatic issue(input logic [NUM_REQ-1:0] vmask, input int hold);
    logic [NUM_REQ-1:0] exp_g;
    int g;
    drive(vmask);
    #1;
    exp_g = model_pick(vmask);
    chk("grant", bus.req_ready, exp_g);
    g = 0;
    for (int i = 0; i < NUM_REQ; i++) if (exp_g[i]) g = i;
    mptr = (g + 1) % NUM_REQ;
    step();
    chk("cmd_ready_low", bus.req_ready, '0);
    bus.req_valid = '0;
    chk("cmd_cs", ram_cs, 1'b1);
    chk("cmd_we", ram_we, cmd_we[g]);
    chk("cmd_oe", ram_oe, !cmd_we[g]);
    chk("cmd_addr", ram_addr, cmd_addr[g]);
    if (cmd_we[g]) begin
      chk("cmd_wdata", ram_wdata, cmd_data[g]);
      mem[cmd_addr[g]] = cmd_data[g];
      step();
      chk("wr_done_cs", ram_cs, 1'b0);
      chk("wr_done_we", ram_we, 1'b0);
    end else begin
      step();
      chk("capt_cs", ram_cs, 1'b1);
      chk("capt_oe", ram_oe, 1'b1);
      chk("capt_we", ram_we, 1'b0);
      chk("capt_rsp_valid", bus.rsp_valid, '0);
      step();
      chk("rsp_valid", bus.rsp_valid, oh(g));
      chk("rsp_data", bus.rsp_data, mem[cmd_addr[g]]);
      chk("rsp_cs", ram_cs, 1'b0);
      for (int h = 0; h < hold; h++) begin
        bus.req_valid = ~oh(g);
        bus.rsp_ready = ~oh(g);
        step();
        chk("bp_valid", bus.rsp_valid, oh(g));
        chk("bp_data", bus.rsp_data, mem[cmd_addr[g]]);
        chk("bp_ready", bus.req_ready, '0);
      end
      bus.req_valid = '0;
      bus.rsp_ready = oh(g);
      step();
      bus.rsp_ready = '0;
      chk("rsp_done", bus.rsp_valid, '0);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = '0;
    for (int r = 0; r < NUM_REQ; r++) set_cmd(r, 1'b0, '0, '0);

    // Reset values, with requests pending during reset.
    bus.req_valid = '1;
    step();
    step();
    chk("rst_req_ready", bus.req_ready, '0);
    chk("rst_rsp_valid", bus.rsp_valid, '0);
    chk("rst_rsp_data", bus.rsp_data, '0);
    chk("rst_ram_cs", ram_cs, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_oe", ram_oe, 1'b0);
    chk("rst_ram_addr", ram_addr, '0);
    chk("rst_ram_wdata", ram_wdata, '0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    step();

    // Single write then readback by the other requester.
    set_cmd(0, 1'b1, 4'd3, 32'h1234_5678);
    issue(2'b01, 0);
    set_cmd(1, 1'b0, 4'd3, 32'h0);
    issue(2'b10, 0);

    // Contention, twice with both valid, then finish req1's write.
    set_cmd(0, 1'b1, 4'd5, 32'h0000_000A);
    set_cmd(1, 1'b1, 4'd6, 32'h0000_000B);
    issue(2'b11, 0);
    issue(2'b11, 0);
    issue(2'b10, 0);

    // Backpressure on a read, then an immediate follow-up command.
    set_cmd(0, 1'b0, 4'd5, 32'h0);
    issue(2'b01, 5);
    set_cmd(1, 1'b0, 4'd6, 32'h0);
    issue(2'b10, 0);

    // Address extremes.
    set_cmd(1, 1'b1, 4'd15, 32'hFFFF_FFFF);
    issue(2'b10, 0);
    set_cmd(0, 1'b1, 4'd0, 32'h0000_0001);
    issue(2'b01, 0);
    set_cmd(0, 1'b0, 4'd15, 32'h0);
    issue(2'b01, 0);
    set_cmd(1, 1'b0, 4'd0, 32'h0);
    issue(2'b10, 0);

    // Reset during CAPT of a read of addr 5.
    set_cmd(1, 1'b0, 4'd5, 32'h0);
    drive(2'b10);
    #1;
    chk("mr_grant", bus.req_ready, model_pick(2'b10));
    step();
    bus.req_valid = '0;
    step();
    chk("mr_capt_cs", ram_cs, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_rsp_valid", bus.rsp_valid, '0);
    chk("mr_rsp_data", bus.rsp_data, '0);
    chk("mr_ram_cs", ram_cs, 1'b0);
    chk("mr_ram_oe", ram_oe, 1'b0);
    chk("mr_ram_addr", ram_addr, '0);
    chk("mr_ram_wdata", ram_wdata, '0);
    step();
    rst_n = 1'b1;
    mptr = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mr_no_rsp", bus.rsp_valid, '0);
      chk("mr_idle_cs", ram_cs, 1'b0);
    end
    set_cmd(0, 1'b0, 4'd15, 32'h0);
    set_cmd(1, 1'b0, 4'd0, 32'h0);
    issue(2'b11, 0);

    // Randomised traffic over a fully initialised memory.
    for (int a = 0; a < DEPTH; a++) begin
      set_cmd(a % NUM_REQ, 1'b1, AW'(a), $urandom);
      issue(oh(a % NUM_REQ), 0);
    end
    for (int t = 0; t < 60; t++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        set_cmd(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom);
      end
      issue(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Shares one `single_port_sync_ram` instance between `NUM_REQ` requesters. Each requester issues read or write commands over a valid/ready handshake. The block arbitrates, sequences the RAM's `cs`/`we`/`oe` controls, and returns read data over a separate valid/ready response channel. It sits directly in front of the RAM; requesters never drive the RAM pins themselves.

## Interface
- `ADDR_WIDTH`, 4, RAM address width
- `DATA_WIDTH`, 32, RAM data width
- `DEPTH`, 16, RAM word count (2**ADDR_WIDTH)
- `NUM_REQ`, 2, number of requesters (2..8)
- Clocking: one clock `clk`; reset is asynchronous and active-low, `rst_n`
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_REQ  command present, per requester
- `req_ready`  out  NUM_REQ  command accepted this cycle (one-hot or zero)
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data
- `rsp_valid`  out  NUM_REQ  read data valid, one-hot to the originating requester
- `rsp_ready`  in  NUM_REQ  requester takes response
- `rsp_data`  out  DATA_WIDTH  read data, shared bus
- `ram_cs`, `ram_we`, `ram_oe`  out  1 each  RAM controls
- `ram_addr`  out  ADDR_WIDTH  RAM address
- `ram_wdata`  out  DATA_WIDTH  RAM write data
- `ram_rdata`  in  DATA_WIDTH  RAM read data, valid the cycle after a read command

## Operation
- FSM states: IDLE, CMD, CAPT, RESP.
- IDLE: if any `req_valid` is set, pick a winner g and assert `req_ready[g]` combinationally, so the handshake completes that cycle. On the edge, latch g, we, addr and wdata, then go to CMD. `req_ready` is 0 in every other state.
- CMD: `ram_cs`=1. For a write, `ram_we`=1 and `ram_oe`=0. For a read, `ram_we`=0 and `ram_oe`=1. `ram_addr`/`ram_wdata` come from the latched values. A write goes next to IDLE; a read goes to CAPT.
- CAPT: `ram_cs`=1 and `ram_oe`=1. Register `ram_rdata` into `rsp_data`, then go to RESP.
- RESP: `rsp_valid[g]`=1 with `rsp_data` held stable. Leave for IDLE on the edge where `rsp_ready[g]`=1. Stay in RESP indefinitely otherwise; no other command is accepted meanwhile.
- Arbitration (see Configuration): fixed priority, with index 0 highest, or round-robin.
- Outside CMD/CAPT, the `ram_*` controls are 0. `ram_addr`/`ram_wdata` hold their last value.
- Address is used as given; ADDR_WIDTH bits cover DEPTH, so no range check is needed.
- Simultaneous valid on all requesters: exactly one `req_ready` is set; the others wait with inputs held stable (requester obligation).
- `req_valid` dropping before `req_ready`: no effect, nothing latched.
- `rsp_ready` of non-owner requesters is ignored.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0
  - `ram_cs`=`ram_we`=`ram_oe`=0, `ram_addr`=0, `ram_wdata`=0
  - FSM=IDLE, RR pointer=0
- Write: accept edge E0; RAM samples at E1. Throughput is 1 write per 2 cycles.
- Read: accept E0; RAM samples at E1; `rsp_data` registered at E2; `rsp_valid` high from E2. Minimum 4 cycles per read including the response cycle with `rsp_ready`=1.
- `rst_n` asserted mid-operation: all outputs go to reset values immediately, any in-flight command is dropped, and no response is issued.

## Configuration
- `SPRAM_ARB_RR_EN` defined: round-robin. After a grant to g, priority starts at (g+1) mod NUM_REQ. The pointer updates only on an accept edge.
- Undefined: fixed priority, lowest index wins, and the pointer logic is absent.

## Structure
- Package `spram_arb_pkg`: FSM state enum (`ST_IDLE`, `ST_CMD`, `ST_CAPT`, `ST_RESP`), plus the `MAX_REQ`=8 constant.
- Sub-module `spram_arb_pick`: combinational winner select from `req_valid` and priority pointer, returning a one-hot grant. The fixed-priority variant is pointer=0.
- `spram_arbiter` contains the FSM, latches and RAM drive. The top-level bench instantiates it with `single_port_sync_ram`.

## Test plan
- Single write: req0 writes addr 3, data 0x12345678. Expect `req_ready[0]` in the same cycle, then `ram_cs`=`ram_we`=1 and `ram_addr`=3 for exactly one cycle.
- Readback: req1 reads addr 3 after the above. Expect `rsp_valid[1]` and `rsp_data`=0x12345678 two edges after accept.
- Contention: req0 and req1 both valid in IDLE, writing 0xA to addr 5 and 0xB to addr 6.
  - Both builds: req0 wins first.
  - With `SPRAM_ARB_RR_EN` and both re-asserting: req1 wins next.
  - Without it: req0 wins again.
- Backpressure: read addr 5 with `rsp_ready`=0 for 5 cycles. `rsp_valid` and `rsp_data`=0xA are held, `req_ready` stays 0 throughout, and the block reaches IDLE one cycle after `rsp_ready`=1.
- Wrap: write 0xFFFFFFFF to addr 15 and 0x1 to addr 0. Read both back correctly.
- Reset mid-read: drop `rst_n` during CAPT. All outputs return to 0, no `rsp_valid` appears, and a new read of addr 15 after release returns 0xFFFFFFFF.
